password_checker: RTL and testbench
===================================

Name: password_checker

Overview:
Reader side of the 4-bit password storage register. Compares a user-entered code against the stored password on an enter strobe and drives a lock state machine. The state machine counts failed tries, enforces a timed lockout after too many failures, and auto-relocks after a timed open window. Sits between the keypad/switch input logic and the door/LED output logic.

Parameters:
PW_W, 4, width of stored and entered password
MAX_TRIES, 3, consecutive failures that trigger lockout (>=1)
LOCKOUT_CYCLES, 1000, clk cycles spent in LOCKOUT (>=1)
UNLOCK_CYCLES, 500, clk cycles spent in OPEN before auto-relock (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
stored_pw  input  PW_W  current stored password from storage register
pw_valid  input  1  high when a password has been programmed
attempt  input  PW_W  entered code, sampled only with enter
enter  input  1  single-cycle strobe: evaluate attempt
relock  input  1  single-cycle strobe: close immediately from OPEN
unlocked  output  1  high while in OPEN
fail_pulse  output  1  one-cycle pulse per rejected attempt
locked_out  output  1  high while in LOCKOUT
tries_left  output  $clog2(MAX_TRIES+1)  MAX_TRIES minus current failure count

Behaviour:
- Reset (async, rst=1): state=IDLE, fail_cnt=0, timer=0.
- Reset values of outputs: unlocked=0, fail_pulse=0, locked_out=0, tries_left=MAX_TRIES.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- States: IDLE, OPEN, LOCKOUT (encoded in shared enum).
- IDLE, enter=1, pw_valid=0: ignored. No state change, no fail count.
- IDLE, enter=1, pw_valid=1, attempt==stored_pw, at that edge:
  - state->OPEN, fail_cnt->0, timer->UNLOCK_CYCLES-1.
  - unlocked=1 from the following cycle (latency 1).
- IDLE, enter=1, pw_valid=1, mismatch, at that edge:
  - fail_pulse=1 for exactly one cycle.
  - If fail_cnt+1 < MAX_TRIES: fail_cnt increments, state stays IDLE.
  - If fail_cnt+1 == MAX_TRIES: state->LOCKOUT, timer->LOCKOUT_CYCLES-1, fail_cnt->MAX_TRIES (tries_left=0).
- stored_pw and attempt are sampled only on the enter cycle. Changes to stored_pw at any other time have no effect on the current state.
- OPEN:
  - timer decrements each cycle.
  - Exit to IDLE on relock=1, or on the cycle timer==0; a simultaneous relock and timeout produce a single exit.
  - enter is ignored; fail_cnt stays 0.
- LOCKOUT:
  - timer decrements each cycle.
  - On the cycle timer==0: state->IDLE, fail_cnt->0.
  - enter and relock are ignored; no fail_pulse.
- Dwell times:
  - OPEN lasts exactly UNLOCK_CYCLES cycles without relock.
  - LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
- Timer width: $clog2(max(LOCKOUT_CYCLES, UNLOCK_CYCLES)). It never underflows; it is loaded only on state entry.
- enter held high for several cycles is treated as one strobe per cycle. Each IDLE cycle with enter=1 is a separate evaluation, so mismatches accumulate.
- Reset asserted in any state (including mid-LOCKOUT or mid-OPEN) returns to reset values immediately. fail history is lost.

Decomposition:
- Shared package pw_pkg:
  - state enum lock_state_t {IDLE, OPEN, LOCKOUT}.
  - Default parameter constants.
- One sub-module, cycle_timer:
  - Loadable down-counter with load, load_value, and a zero flag.
  - Instantiated once and reused for both OPEN and LOCKOUT durations.

Test Plan:
- Test parameters for all scenarios: MAX_TRIES=3, LOCKOUT_CYCLES=8, UNLOCK_CYCLES=5.
- Reset, stored_pw=4'hA, pw_valid=1, enter with attempt=4'hA -> unlocked=1 next cycle for exactly 5 cycles, then 0; tries_left=3 throughout.
- attempt=4'h3 entered 3 times in IDLE -> fail_pulse 3 single-cycle pulses; tries_left goes 3,2,1,0; locked_out=1 for 8 cycles. Correct attempt=4'hA during lockout -> ignored. After lockout, tries_left=3.
- Two mismatches, then attempt=4'hA -> unlocked=1, tries_left returns to 3. A later single mismatch -> tries_left=2, no lockout.
- In OPEN, relock pulsed on the 2nd open cycle -> unlocked drops next cycle. relock coincident with timeout -> single return to IDLE, no glitch.
- pw_valid=0, enter with any attempt -> no fail_pulse, no state change, tries_left stays 3.
- rst asserted mid-LOCKOUT (cycle 4 of 8) -> locked_out=0 immediately, tries_left=3. Next correct entry unlocks.

Source files
------------

// File: rtl/pw_pkg.sv
// Shared types and defaults for the password checker: lock FSM states,
// parameter defaults and a timer-width helper.
package pw_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } lock_state_t;

  localparam int DEF_PW_W           = 4;
  localparam int DEF_MAX_TRIES      = 3;
  localparam int DEF_LOCKOUT_CYCLES = 1000;
  localparam int DEF_UNLOCK_CYCLES  = 500;

  // Timer holds at most max(a,b)-1; never collapse to a zero-width vector.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter with a zero flag; one instance serves both the
// OPEN window and the LOCKOUT period.
module cycle_timer
  import pw_pkg::*;
#(
  parameter int W = timer_width(DEF_LOCKOUT_CYCLES, DEF_UNLOCK_CYCLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/password_checker.sv
// Lock FSM: evaluates entered codes on enter, counts failures, enforces a
// timed lockout and auto-relocks after a timed open window.
//
// state   | meaning
// IDLE    | locked, accepting attempts
// OPEN    | correct code accepted; relocks on relock or window timeout
// LOCKOUT | too many failures; attempts ignored until timeout
module password_checker
  import pw_pkg::*;
#(
  parameter int PW_W           = DEF_PW_W,
  parameter int MAX_TRIES      = DEF_MAX_TRIES,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
  parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
  localparam int FW = $clog2(MAX_TRIES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PW_W-1:0] stored_pw,
  input  logic            pw_valid,
  input  logic [PW_W-1:0] attempt,
  input  logic            enter,
  input  logic            relock,
  output logic            unlocked,
  output logic            fail_pulse,
  output logic            locked_out,
  output logic [FW-1:0]   tries_left
);

  localparam int TW = timer_width(LOCKOUT_CYCLES, UNLOCK_CYCLES);

  lock_state_t   r_state;
  logic [FW-1:0] r_fail_cnt;
  logic          r_fail_pulse;

  logic          w_eval;
  logic          w_match;
  logic          w_last_try;
  logic          w_load;
  logic [TW-1:0] w_load_value;
  logic          w_zero;

  assign w_eval     = (r_state == IDLE) && enter && pw_valid;
  assign w_match    = (attempt == stored_pw);
  assign w_last_try = (r_fail_cnt == FW'(MAX_TRIES - 1));

  // The timer is only loaded on entry to OPEN or LOCKOUT.
  assign w_load       = w_eval && (w_match || w_last_try);
  assign w_load_value = w_match ? TW'(UNLOCK_CYCLES - 1) : TW'(LOCKOUT_CYCLES - 1);

  cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (w_load),
    .en         (r_state != IDLE),
    .load_value (w_load_value),
    .zero       (w_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_fail_cnt   <= '0;
      r_fail_pulse <= 1'b0;
    end else begin
      r_fail_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_eval) begin
            if (w_match) begin
              r_state    <= OPEN;
              r_fail_cnt <= '0;
            end else begin
              r_fail_pulse <= 1'b1;
              if (w_last_try) begin
                r_state    <= LOCKOUT;
                r_fail_cnt <= FW'(MAX_TRIES);
              end else begin
                r_fail_cnt <= r_fail_cnt + 1'b1;
              end
            end
          end
        end
        OPEN: begin
          if (relock || w_zero) r_state <= IDLE;
        end
        LOCKOUT: begin
          if (w_zero) begin
            r_state    <= IDLE;
            r_fail_cnt <= '0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_fail_cnt <= '0;
        end
      endcase
    end
  end

  assign unlocked   = (r_state == OPEN);
  assign locked_out = (r_state == LOCKOUT);
  assign fail_pulse = r_fail_pulse;
  assign tries_left = FW'(MAX_TRIES) - r_fail_cnt;

endmodule

// File: tb/tb_password_checker.sv
// Self-checking bench for password_checker: directed scenarios with literal
// expectations, then randomized traffic against a deadline-based model.
module tb_password_checker;

  localparam int PW_W = 4;
  localparam int MT   = 3;
  localparam int LC   = 8;
  localparam int UC   = 5;
  localparam int FW   = $clog2(MT + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic [PW_W-1:0] stored_pw;
  logic            pw_valid;
  logic [PW_W-1:0] attempt;
  logic            enter;
  logic            relock;
  logic            unlocked;
  logic            fail_pulse;
  logic            locked_out;
  logic [FW-1:0]   tries_left;

  password_checker #(
    .PW_W(PW_W), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC), .UNLOCK_CYCLES(UC)
  ) dut (
    .clk(clk), .rst(rst), .stored_pw(stored_pw), .pw_valid(pw_valid),
    .attempt(attempt), .enter(enter), .relock(relock),
    .unlocked(unlocked), .fail_pulse(fail_pulse), .locked_out(locked_out),
    .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: mode 0=locked/idle, 1=open, 2=lockout; each timed mode ends at a
  // fixed edge number computed when it is entered.
  int m_mode;
  int m_fails;
  int m_end;
  bit m_pulse;
  int edge_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_fails = 0;
    m_end   = 0;
    m_pulse = 0;
  endtask

  task automatic model_edge();
    edge_n++;
    m_pulse = 0;
    case (m_mode)
      0: if (enter && pw_valid) begin
           if (attempt == stored_pw) begin
             m_mode  = 1;
             m_fails = 0;
             m_end   = edge_n + UC;
           end else begin
             m_pulse = 1;
             m_fails++;
             if (m_fails == MT) begin
               m_mode = 2;
               m_end  = edge_n + LC;
             end
           end
         end
      1: if (relock || edge_n == m_end) m_mode = 0;
      default: if (edge_n == m_end) begin
                 m_mode  = 0;
                 m_fails = 0;
               end
    endcase
  endtask

  task automatic compare_all();
    chk("unlocked",   {31'd0, unlocked},   {31'd0, m_mode == 1});
    chk("fail_pulse", {31'd0, fail_pulse}, {31'd0, m_pulse});
    chk("locked_out", {31'd0, locked_out}, {31'd0, m_mode == 2});
    chk("tries_left", 32'(tries_left),     32'(MT - m_fails));
  endtask

  task automatic step(input bit e, input logic [PW_W-1:0] a, input bit r);
    enter   = e;
    attempt = a;
    relock  = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    enter  = 1'b0;
    relock = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    edge_n    = 0;
    enter     = 0;
    relock    = 0;
    attempt   = '0;
    stored_pw = 4'hA;
    pw_valid  = 1'b1;
    @(negedge clk);
    do_reset();
    chk("reset_tries_left", 32'(tries_left), 32'd3);
    chk("reset_unlocked",   {31'd0, unlocked}, 32'd0);

    // Correct code: open for exactly UC cycles.
    step(1, 4'hA, 0);
    n = unlocked ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 4'h0, 0);
      if (unlocked) n++;
      chk("open_tries_left", 32'(tries_left), 32'd3);
    end
    chk("open_dwell", n, 32'd5);

    // Three mismatches into lockout; a correct code during lockout is ignored.
    for (int k = 0; k < 3; k++) begin
      step(1, 4'h3, 0);
      chk("mismatch_pulse", {31'd0, fail_pulse}, 32'd1);
      chk("mismatch_tries", 32'(tries_left), 32'(2 - k));
      if (k < 2) begin
        step(0, 4'h0, 0);
        chk("pulse_single", {31'd0, fail_pulse}, 32'd0);
      end
    end
    chk("lockout_entered", {31'd0, locked_out}, 32'd1);
    n = 1;
    step(1, 4'hA, 0);
    if (locked_out) n++;
    chk("lockout_ignores_enter", {31'd0, unlocked}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step(0, 4'h0, 0);
      if (locked_out) n++;
    end
    chk("lockout_dwell", n, 32'd8);
    chk("after_lockout_tries", 32'(tries_left), 32'd3);

    // Two mismatches, then correct code resets the failure count.
    step(1, 4'h3, 0);
    step(1, 4'h5, 0);
    chk("two_fail_tries", 32'(tries_left), 32'd1);
    step(1, 4'hA, 0);
    chk("recover_unlocked", {31'd0, unlocked}, 32'd1);
    chk("recover_tries", 32'(tries_left), 32'd3);
    for (int i = 0; i < 6; i++) step(0, 4'h0, 0);
    step(1, 4'h3, 0);
    chk("single_fail_tries", 32'(tries_left), 32'd2);
    step(0, 4'h0, 0);
    chk("single_fail_no_lockout", {31'd0, locked_out}, 32'd0);

    // Relock on the second open cycle, then relock coincident with timeout.
    do_reset();
    step(1, 4'hA, 0);
    step(0, 4'h0, 0);
    chk("open_cycle2", {31'd0, unlocked}, 32'd1);
    step(0, 4'h0, 1);
    chk("relock_closes", {31'd0, unlocked}, 32'd0);
    step(1, 4'hA, 0);
    for (int i = 0; i < 4; i++) step(0, 4'h0, 0);
    chk("open_cycle5", {31'd0, unlocked}, 32'd1);
    step(0, 4'h0, 1);
    chk("relock_timeout_closed", {31'd0, unlocked}, 32'd0);
    step(0, 4'h0, 0);
    chk("relock_timeout_stays", {31'd0, unlocked}, 32'd0);

    // No password programmed: entries are ignored.
    pw_valid = 1'b0;
    step(1, 4'h3, 0);
    chk("invalid_no_pulse", {31'd0, fail_pulse}, 32'd0);
    step(1, 4'hA, 0);
    chk("invalid_no_open", {31'd0, unlocked}, 32'd0);
    chk("invalid_tries", 32'(tries_left), 32'd3);
    pw_valid = 1'b1;

    // Reset in the middle of lockout.
    step(1, 4'h3, 0);
    step(1, 4'h3, 0);
    step(1, 4'h3, 0);
    for (int i = 0; i < 3; i++) step(0, 4'h0, 0);
    chk("lockout_cycle4", {31'd0, locked_out}, 32'd1);
    do_reset();
    chk("mid_lockout_reset", {31'd0, locked_out}, 32'd0);
    chk("mid_lockout_tries", 32'(tries_left), 32'd3);
    step(1, 4'hA, 0);
    chk("post_reset_unlock", {31'd0, unlocked}, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [PW_W-1:0] a;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 19) == 0) stored_pw = PW_W'($urandom);
        if ($urandom_range(0, 29) == 0) pw_valid = ~pw_valid;
        a = ($urandom_range(0, 9) < 4) ? stored_pw : PW_W'($urandom);
        step($urandom_range(0, 9) < 3, a, $urandom_range(0, 9) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
